// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI sawtooth DAC generator.
package spi_dac_pkg;

    localparam int unsigned FRAME_W = 32;
    localparam int unsigned DATA_W  = 12;

    localparam logic [3:0] CMD_DEF  = 4'b0011;
    localparam logic [3:0] ADDR_DEF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    typedef struct packed {
        logic [7:0]        pad;
        logic [3:0]        cmd;
        logic [3:0]        addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        tail;
    } frame_t;

    // Build one write-and-update frame around a sample.
    function automatic frame_t make_frame(input logic [3:0] cmd, input logic [3:0] addr,
                                          input logic [DATA_W-1:0] data);
        frame_t f;
        f.pad  = 8'h00;
        f.cmd  = cmd;
        f.addr = addr;
        f.data = data;
        f.tail = 4'h0;
        return f;
    endfunction

endpackage

// File: rtl/spi_dac_generator_if.sv
// Board-side DAC pin bundle plus scope/LA debug copies.
interface spi_dac_if;

    logic spi_mosi;
    logic dac_cs;
    logic dac_clr;
    logic spi_sck;
    logic cs_test;
    logic clk_test;

    modport master (
        output spi_mosi,
        output dac_cs,
        output dac_clr,
        output spi_sck,
        output cs_test,
        output clk_test
    );

    modport slave (
        input spi_mosi,
        input dac_cs,
        input dac_clr,
        input spi_sck,
        input cs_test,
        input clk_test
    );

endinterface

// File: rtl/dac_spi_tx.sv
// SPI frame serialiser: loads a word on start and shifts it out MSB first,
// SCK idles low, MOSI changes only on falling SCK.
module dac_spi_tx
    import spi_dac_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] word,
    output logic               sck,
    output logic               mosi,
    output logic               cs,
    output logic               done_c
);

    localparam int unsigned HC_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_W);

    logic [HC_W-1:0]    hcnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [FRAME_W-2:0] shreg;
    logic               half_end;
    logic               last_bit;

    assign half_end = (hcnt == HC_W'(N - 1));
    assign last_bit = (bit_idx == BIT_W'(FRAME_W - 1));
    // High in the cycle whose closing edge drops SCK for the last time.
    assign done_c   = !cs && sck && half_end && last_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck     <= 1'b0;
            mosi    <= 1'b0;
            cs      <= 1'b1;
            hcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (start) begin
            cs      <= 1'b0;
            sck     <= 1'b0;
            mosi    <= word[FRAME_W-1];
            shreg   <= word[FRAME_W-2:0];
            hcnt    <= '0;
            bit_idx <= '0;
        end else if (!cs) begin
            if (half_end) begin
                hcnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    sck <= 1'b0;
                    if (last_bit) begin
                        cs   <= 1'b1;
                        mosi <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        mosi    <= shreg[FRAME_W-2];
                        shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                    end
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_dac_generator.sv
// Free-running sawtooth generator: one 32-bit DAC frame per sample, then
// a fixed gap, with the sample advancing by STEP each frame.
module spi_dac_generator
    import spi_dac_pkg::*;
#(
    parameter int unsigned       N    = 8,
    parameter logic [DATA_W-1:0] STEP = 12'd1,
    parameter logic [3:0]        CMD  = CMD_DEF,
    parameter logic [3:0]        ADDR = ADDR_DEF
) (
    input  logic      clk,
    input  logic      rst,
    spi_dac_if.master dac
);

    // GAP covers 2N-1 cycles; the LOAD cycle completes the 2N-cycle CS-high window.
    localparam int unsigned GAP_CYC = 2 * N - 1;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] sample;
    logic              clr_q;
    logic              gap_last_c;
    logic              start_c;
    logic              adv_c;
    logic              done_c;
    logic              sck;
    logic              mosi;
    logic              cs;
    frame_t            word_c;

    assign gap_last_c = (gap_cnt == GAP_W'(GAP_CYC - 1));
    assign word_c     = make_frame(CMD, ADDR, sample);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (done_c) state_nxt = GAP;
            GAP:     if (gap_last_c) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_c = 1'b0;
        adv_c   = 1'b0;
        case (state)
            LOAD:    start_c = 1'b1;
            GAP:     adv_c   = gap_last_c;
            default: ;
        endcase
    end

    // Sample counter, gap timer and the DAC clear release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
            sample  <= '0;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= 1'b1;
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (adv_c) begin
                sample <= sample + STEP;
            end
        end
    end

    dac_spi_tx #(
        .N (N)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .word   (word_c),
        .sck    (sck),
        .mosi   (mosi),
        .cs     (cs),
        .done_c (done_c)
    );

    assign dac.spi_mosi = mosi;
    assign dac.dac_cs   = cs;
    assign dac.dac_clr  = clr_q;
    assign dac.spi_sck  = sck;
    assign dac.cs_test  = cs;
    assign dac.clk_test = sck;

endmodule

// File: tb/tb_spi_dac_generator.sv
// Directed bench for spi_dac_generator: two instances (STEP=1 and STEP=12'h800), N=3.
module tb_spi_dac_generator;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    spi_dac_if ifa ();
    spi_dac_if ifb ();

    spi_dac_generator #(.N(3), .STEP(12'd1))   dut_a (.clk(clk), .rst(rst), .dac(ifa));
    spi_dac_generator #(.N(3), .STEP(12'h800)) dut_b (.clk(clk), .rst(rst), .dac(ifb));

    logic m_sck, m_mosi, m_cs, m_clr, m_cs_test, m_clk_test;
    assign m_sck      = sel ? ifb.spi_sck  : ifa.spi_sck;
    assign m_mosi     = sel ? ifb.spi_mosi : ifa.spi_mosi;
    assign m_cs       = sel ? ifb.dac_cs   : ifa.dac_cs;
    assign m_clr      = sel ? ifb.dac_clr  : ifa.dac_clr;
    assign m_cs_test  = sel ? ifb.cs_test  : ifa.cs_test;
    assign m_clk_test = sel ? ifb.clk_test : ifa.clk_test;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cs"},       32'(m_cs),       32'd1);
        chk({tag, "_sck"},      32'(m_sck),      32'd0);
        chk({tag, "_mosi"},     32'(m_mosi),     32'd0);
        chk({tag, "_clr"},      32'(m_clr),      32'd0);
        chk({tag, "_cs_test"},  32'(m_cs_test),  32'd1);
        chk({tag, "_clk_test"}, 32'(m_clk_test), 32'd0);
    endtask

    // Release reset and walk to just after the first frame's CS fall.
    task automatic start_seq(input string tag);
        @(negedge clk);
        rst = 1'b1;
        step_edge();
        chk({tag, "_e1_clr"}, 32'(m_clr), 32'd1);
        chk({tag, "_e1_cs"},  32'(m_cs),  32'd1);
        step_edge();
        chk({tag, "_e2_cs"},   32'(m_cs),   32'd0);
        chk({tag, "_e2_mosi"}, 32'(m_mosi), 32'd0);
    endtask

    // Capture one frame on SCK rising, starting right after CS fell.
    task automatic grab(output logic [31:0] w, output int pulses, output int rise1,
                        output int elapsed, output int mosi_bad, output int copy_bad);
        logic ps;
        logic pm;
        w = '0; pulses = 0; rise1 = -1; elapsed = -1; mosi_bad = 0; copy_bad = 0;
        ps = m_sck;
        pm = m_mosi;
        for (int i = 1; i <= 400; i++) begin
            step_edge();
            if (m_cs_test !== m_cs || m_clk_test !== m_sck) copy_bad++;
            if (m_mosi !== pm && m_sck !== 1'b0) mosi_bad++;
            if (m_sck && !ps) begin
                w = {w[30:0], m_mosi};
                pulses++;
                if (rise1 < 0) rise1 = i;
            end
            ps = m_sck;
            pm = m_mosi;
            if (m_cs) begin
                elapsed = i;
                break;
            end
        end
    endtask

    // Measure the CS-high window; returns just after the next CS fall.
    task automatic gap(output int hi, output int gap_bad);
        hi = 1;
        gap_bad = (m_sck !== 1'b0 || m_mosi !== 1'b0) ? 1 : 0;
        for (int i = 0; i < 50; i++) begin
            step_edge();
            if (!m_cs) break;
            hi++;
            if (m_sck !== 1'b0 || m_mosi !== 1'b0) gap_bad++;
        end
    endtask

    task automatic frame(input string tag, input logic [31:0] exp);
        logic [31:0] w;
        int pulses, rise1, elapsed, mosi_bad, copy_bad, hi, gap_bad;
        grab(w, pulses, rise1, elapsed, mosi_bad, copy_bad);
        chk({tag, "_word"},     w,                 exp);
        chk({tag, "_pulses"},   32'(pulses),       32'd32);
        chk({tag, "_rise1"},    32'(rise1),        32'd3);
        chk({tag, "_cs_low"},   32'(elapsed),      32'd192);
        chk({tag, "_mosi_chg"}, 32'(mosi_bad),     32'd0);
        chk({tag, "_copies"},   32'(copy_bad),     32'd0);
        gap(hi, gap_bad);
        chk({tag, "_gap_len"},  32'(hi),           32'd6);
        chk({tag, "_gap_idle"}, 32'(gap_bad),      32'd0);
        chk({tag, "_period"},   32'(elapsed + hi), 32'd198);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel   = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst_a");
        sel = 1'b1;
        check_reset("rst_b");

        sel = 1'b0;
        start_seq("a");
        frame("a_f0", 32'h003F_0000);
        frame("a_f1", 32'h003F_0010);
        frame("a_f2", 32'h003F_0020);

        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        check_reset("rst_b2");
        start_seq("b");
        frame("b_f0", 32'h003F_0000);
        frame("b_f1", 32'h003F_8000);
        frame("b_f2", 32'h003F_0000);

        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        start_seq("c");
        frame("c_f0", 32'h003F_0000);
        // Bit 10 of frame 1 occupies cycles t0+60..t0+65.
        repeat (62) step_edge();
        chk("c_mid_cs", 32'(m_cs), 32'd0);
        rst = 1'b0;
        #1;
        check_reset("c_midrst");
        repeat (2) @(negedge clk);
        start_seq("c2");
        frame("c2_f0", 32'h003F_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
